// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a prescaled up-counter.
// Runs one-shot or periodic to a loaded terminal count.
module counter_sequencer #(
   parameter int WIDTH   = 32,
   parameter int PRESC_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   output logic [WIDTH-1:0] count_out,
   output logic             match_pulse,
   output logic             done,
   output logic             cmd_err,
   output logic [1:0]       state_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_LIMIT  = 3'd1;
   localparam logic [2:0] OP_PRESC  = 3'd2;
   localparam logic [2:0] OP_ONE    = 3'd3;
   localparam logic [2:0] OP_PER    = 3'd4;
   localparam logic [2:0] OP_PAUSE  = 3'd5;
   localparam logic [2:0] OP_RESUME = 3'd6;
   localparam logic [2:0] OP_STOP   = 3'd7;

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   limit_q, limit_d;
   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               per_q, per_d;
   logic               match_q, match_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               rdy_q, rdy_d;

   logic               accept;
   logic               idle_or_done;
   logic [WIDTH-1:0]   count_inc;

   assign accept       = cmd_valid && rdy_q;
   assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
   assign count_inc    = count_q + WIDTH'(1);

   // State and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         limit_q <= '0;
         pcnt_q  <= '0;
         presc_q <= '0;
         per_q   <= 1'b0;
         match_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         limit_q <= limit_d;
         pcnt_q  <= pcnt_d;
         presc_q <= presc_d;
         per_q   <= per_d;
         match_q <= match_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
      end
   end

   // Next state: run stepping first, then an accepted command overrides it
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      limit_d = limit_q;
      pcnt_d  = pcnt_q;
      presc_d = presc_q;
      per_d   = per_q;
      match_d = 1'b0;
      err_d   = 1'b0;
      rdy_d   = !accept;

      if (state_q == S_RUN) begin
         if (pcnt_q == presc_q) begin
            pcnt_d = '0;
            if (count_q != limit_q) begin
               count_d = count_inc;
               if (count_inc == limit_q) begin
                  match_d = 1'b1;
                  if (!per_q) state_d = S_DONE;
               end
            end else begin
               count_d = '0;
            end
         end else begin
            pcnt_d = pcnt_q + PRESC_W'(1);
         end
      end

      if (accept) begin
         unique case (cmd_op)
            OP_NOP: ;
            OP_LIMIT: begin
               if (idle_or_done) limit_d = cmd_arg;
               else              err_d   = 1'b1;
            end
            OP_PRESC: begin
               if (idle_or_done) presc_d = cmd_arg[PRESC_W-1:0];
               else              err_d   = 1'b1;
            end
            OP_ONE, OP_PER: begin
               if (idle_or_done && limit_q != '0) begin
                  count_d = '0;
                  pcnt_d  = '0;
                  per_d   = (cmd_op == OP_PER);
                  state_d = S_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_PAUSE: begin
               if (state_q == S_RUN) begin
                  count_d = count_q;
                  pcnt_d  = pcnt_q;
                  match_d = 1'b0;
                  state_d = S_PAUSE;
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_RESUME: begin
               if (state_q == S_PAUSE) state_d = S_RUN;
               else                    err_d   = 1'b1;
            end
            OP_STOP: begin
               count_d = '0;
               pcnt_d  = '0;
               match_d = 1'b0;
               state_d = S_IDLE;
            end
            default: ;
         endcase
      end

      done_d = (state_d == S_DONE);
   end

   // Outputs come straight from registers
   always_comb begin
      cmd_ready   = rdy_q;
      count_out   = count_q;
      match_pulse = match_q;
      done        = done_q;
      cmd_err     = err_q;
      state_out   = state_q;
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer.
// Expected values are hand-derived from the command timing.
module tb_counter_sequencer;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_op = 3'd0;
   logic [W-1:0] cmd_arg = '0;
   logic [W-1:0] count_out;
   logic         match_pulse;
   logic         done;
   logic         cmd_err;
   logic [1:0]   state_out;

   int checks = 0;
   int errors = 0;

   counter_sequencer #(.WIDTH(W), .PRESC_W(8)) dut (
      .clock(clock),
      .reset(reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_arg(cmd_arg),
      .count_out(count_out),
      .match_pulse(match_pulse),
      .done(done),
      .cmd_err(cmd_err),
      .state_out(state_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one command; returns 1 time unit after the accepting edge
   task automatic send(input logic [2:0] op, input logic [W-1:0] arg);
      int n;
      n = 0;
      while (!cmd_ready && n < 4) begin
         tick();
         n++;
      end
      if (!cmd_ready) chk("ready_timeout", {31'd0, cmd_ready}, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_arg   = '0;
   endtask

   initial begin
      reset = 1'b0;
      #12;
      reset = 1'b1;
      tick();

      // reset values
      chk("rst_state", 32'(state_out), 0);
      chk("rst_count", count_out, 0);
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_match", 32'(match_pulse), 0);
      chk("rst_err", 32'(cmd_err), 0);

      // START with limit 0 is an error
      send(3'd3, 0);
      chk("lim0_err", 32'(cmd_err), 1);
      chk("lim0_state", 32'(state_out), 0);
      chk("lim0_rdy_lo", 32'(cmd_ready), 0);
      tick();
      chk("lim0_err_clr", 32'(cmd_err), 0);
      chk("lim0_rdy_hi", 32'(cmd_ready), 1);

      // oneshot to 5, presc 0
      send(3'd1, 5);
      tick();
      send(3'd2, 0);
      tick();
      send(3'd3, 0);
      chk("os_state_run", 32'(state_out), 1);
      chk("os_count0", count_out, 0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("os_count", count_out, 32'(i));
         chk("os_match", 32'(match_pulse), (i == 5) ? 1 : 0);
         chk("os_done", 32'(done), (i == 5) ? 1 : 0);
      end
      chk("os_state_done", 32'(state_out), 3);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("os_hold", count_out, 5);
         chk("os_hold_match", 32'(match_pulse), 0);
      end
      chk("os_hold_state", 32'(state_out), 3);

      // periodic limit 3 presc 2: period 12, match at t%12==9
      send(3'd1, 3);
      tick();
      send(3'd2, 2);
      tick();
      send(3'd4, 0);
      chk("per_done_clr", 32'(done), 0);
      chk("per_count0", count_out, 0);
      for (int t = 1; t <= 36; t++) begin
         tick();
         chk("per_count", count_out, 32'((t / 3) % 4));
         chk("per_match", 32'(match_pulse), (t % 12 == 9) ? 1 : 0);
      end
      chk("per_state", 32'(state_out), 1);
      send(3'd7, 0);
      chk("stop_state", 32'(state_out), 0);
      chk("stop_count", count_out, 0);
      tick();

      // periodic limit 10 presc 0; PAUSE on the 4->5 step edge
      send(3'd1, 10);
      tick();
      send(3'd2, 0);
      tick();
      send(3'd4, 0);
      for (int t = 1; t <= 4; t++) begin
         tick();
         chk("pz_count", count_out, 32'(t));
      end
      send(3'd5, 0);
      chk("pz_state", 32'(state_out), 2);
      chk("pz_frozen", count_out, 4);
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("pz_hold", count_out, 4);
         chk("pz_match", 32'(match_pulse), 0);
      end
      send(3'd6, 0);
      chk("rs_state", 32'(state_out), 1);
      chk("rs_count", count_out, 4);
      tick();
      chk("rs_count5", count_out, 5);
      tick();
      chk("rs_count6", count_out, 6);

      // illegal commands in RUN
      send(3'd1, 99);
      chk("il_setlim_err", 32'(cmd_err), 1);
      chk("il_setlim_st", 32'(state_out), 1);
      tick();
      send(3'd6, 0);
      chk("il_resume_err", 32'(cmd_err), 1);
      chk("il_resume_st", 32'(state_out), 1);
      tick();
      send(3'd5, 0);
      chk("pz2_err", 32'(cmd_err), 0);
      chk("pz2_state", 32'(state_out), 2);
      tick();
      send(3'd3, 0);
      chk("il_start_err", 32'(cmd_err), 1);
      chk("il_start_st", 32'(state_out), 2);
      tick();

      // STOP from PAUSED, then oneshot reaches the retained limit 10
      send(3'd7, 0);
      chk("stp_err", 32'(cmd_err), 0);
      chk("stp_state", 32'(state_out), 0);
      chk("stp_count", count_out, 0);
      tick();
      send(3'd3, 0);
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (t == 9) begin
            chk("old_lim_c9", count_out, 9);
            chk("old_lim_d9", 32'(done), 0);
         end
      end
      chk("old_lim_count", count_out, 10);
      chk("old_lim_done", 32'(done), 1);
      chk("old_lim_match", 32'(match_pulse), 1);
      chk("old_lim_state", 32'(state_out), 3);

      // STOP from DONE, then PAUSE and STOP in IDLE
      send(3'd7, 0);
      chk("stpd_done", 32'(done), 0);
      tick();
      send(3'd5, 0);
      chk("il_pause_err", 32'(cmd_err), 1);
      chk("il_pause_st", 32'(state_out), 0);
      tick();
      send(3'd7, 0);
      chk("idle_stop_err", 32'(cmd_err), 0);
      tick();
      send(3'd0, 0);
      chk("nop_err", 32'(cmd_err), 0);
      tick();

      // async reset mid-run at count 7
      send(3'd4, 0);
      for (int t = 1; t <= 7; t++) tick();
      chk("ar_pre_count", count_out, 7);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_count", count_out, 0);
      chk("ar_state", 32'(state_out), 0);
      chk("ar_ready", 32'(cmd_ready), 1);
      chk("ar_done", 32'(done), 0);
      chk("ar_match", 32'(match_pulse), 0);
      #3;
      reset = 1'b1;
      tick();
      send(3'd3, 0);
      chk("ar_lim0_err", 32'(cmd_err), 1);
      chk("ar_lim0_st", 32'(state_out), 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Command-driven controller that sequences a WIDTH-bit up-counter datapath: loads a terminal value and a prescaler, then runs it one-shot or periodic.
- Supports start, pause, resume and stop, and flags match and done.
- Sits between a host or command source and downstream logic that consumes count_out, match_pulse and done.
- Replaces free-running counters where start/stop control and a terminal count are needed.

Parameters:
- WIDTH, 32, counter and limit width in bits.
- PRESC_W, 8, prescaler width in bits.

Ports:
- clock  input  1  single system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  0 NOP, 1 SET_LIMIT, 2 SET_PRESC, 3 START_ONESHOT, 4 START_PERIODIC, 5 PAUSE, 6 RESUME, 7 STOP.
- cmd_arg  input  WIDTH  operand; SET_PRESC uses cmd_arg[PRESC_W-1:0].
- count_out  output  WIDTH  current count.
- match_pulse  output  1  one-cycle pulse when count_out first equals limit.
- done  output  1  high while in DONE.
- cmd_err  output  1  one-cycle pulse for an illegal command.
- state_out  output  2  0 IDLE, 1 RUN, 2 PAUSED, 3 DONE.

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE; count, prescale counter, limit and presc registers = 0; mode = oneshot.
  - match_pulse, done and cmd_err = 0; cmd_ready = 1.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
  - cmd_ready drops to 0 for exactly the one cycle after each acceptance, then returns to 1. Back-to-back commands are therefore spaced by at least 2 cycles.
  - cmd_op and cmd_arg are sampled only at acceptance.
- Every output is registered. cmd_err is high during the cycle after the accepting edge; the command has no other effect.
- Legality by state:
  - SET_LIMIT and SET_PRESC: legal in IDLE and DONE only; the register updates at the accepting edge.
  - START_*: legal in IDLE and DONE. If limit == 0, START is an error. Otherwise, at the accepting edge: count = 0, prescale counter = 0, mode latched, state goes to RUN, done clears.
  - PAUSE: legal only in RUN, goes to PAUSED. RESUME: legal only in PAUSED, goes to RUN.
  - STOP: legal in any state. It goes to IDLE and clears count and the prescale counter; limit and presc are retained. STOP in IDLE is a no-op, not an error.
  - NOP: never an error.
- RUN stepping:
  - Each cycle the prescale counter increments.
  - When it equals presc, it wraps to 0 and a step occurs.
  - Step with count != limit: count = count + 1.
  - Step with count == limit, periodic: count = 0, state stays RUN.
  - match_pulse asserts in the first cycle count_out == limit, i.e. the same edge count becomes limit. It stays high 1 cycle only, however long count holds at limit.
  - Oneshot: the edge that makes count == limit also moves the state to DONE and sets done. count_out holds limit until STOP or START.
  - Periodic period = (limit+1)*(presc+1) cycles; match_pulse recurs once per period.
- PAUSED: count and prescale counter frozen; no steps; no match_pulse.
- Simultaneous events:
  - A command accepted on the same edge as a step wins; the step is discarded.
  - Exception: SET_* and START are not legal in RUN, so they cannot collide with a step.
  - A PAUSE accepted on a step edge freezes the pre-step values.
- Arithmetic: count is unsigned WIDTH bits. count never exceeds limit, so no wrap past 2^WIDTH-1. limit = 2^WIDTH-1 is legal.
- Reset mid-run: immediate return to IDLE reset values, including limit and presc = 0.

Test Plan:
- Reset, then START_ONESHOT with limit = 0 -> cmd_err pulses 1 cycle; state_out stays 0; cmd_ready low 1 cycle then high.
- SET_LIMIT 5, SET_PRESC 0, START_ONESHOT -> count_out 0,1,2,3,4,5 on consecutive cycles; match_pulse and done rise on the cycle count_out = 5; state_out = 3; count_out holds 5 for 20 cycles.
- SET_LIMIT 3, SET_PRESC 2, START_PERIODIC -> each value held 3 cycles; match_pulse every 12 cycles; count wraps 3->0; run 3 periods.
- Periodic run, limit 10: PAUSE at count 4 -> count frozen at 4 for 15 cycles with no match_pulse; RESUME -> continues 5,6,… Also issue PAUSE on a step edge and check the pre-step value is held.
- Illegal commands: SET_LIMIT in RUN, RESUME in RUN, PAUSE in IDLE, START in PAUSED -> each gives a 1-cycle cmd_err with no state or register change. STOP from PAUSED -> IDLE, count 0, limit retained; a later START runs to the old limit.
- Assert reset asynchronously between clock edges in RUN with count = 7 -> all outputs take reset values before the next edge; after release, START errors because limit = 0.
